scroll_key_conditioner: RTL

Input-conditioning stage directly upstream of the scroll position FSM on the board. It takes the two raw pushbutton levels (left/right), synchronizes and debounces each one, and emits single-cycle press pulses that drive the scroller's left/right step inputs. Optional auto-repeat emits further pulses while a key stays held. The two channels are identical and independent.

---
 rtl/scroll_key_conditioner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/scroll_key_conditioner.sv
// Purpose: synchronize, debounce and auto-repeat two raw pushbuttons into one-cycle step pulses.
// Latency: press pulse is registered DEBOUNCE_CYCLES+3 edges after the raw key first reads pressed.
// Backpressure: none; pulses are fire-and-forget and both channels may pulse in the same cycle.

module scroll_key_channel #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_EN       = 1,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_REPEAT,
    S_RELEASE_WAIT
  } state_t;

  localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] L_DEB  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] L_HOLD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] L_REP  = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] L_ONE  = CW'(1);
  localparam logic [CW-1:0] L_ZERO = '0;
  localparam logic          L_REPEAT_ON   = (REPEAT_EN != 0);
  // Raw level the pin shows while the button is not pressed.
  localparam logic          L_RELEASED_LVL = (ACTIVE_LOW != 0);

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_pulse_nxt;
  logic          w_pressed;

  // Two-flop synchronizer on the raw level; reset parks it at the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= L_RELEASED_LVL;
      r_sync2 <= L_RELEASED_LVL;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  // Polarity normalized after synchronization: 1 means pressed.
  assign w_pressed = r_sync2 ^ L_RELEASED_LVL;
  assign w_cnt_inc = r_cnt + L_ONE;

  // State, counter and registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= L_ZERO;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // Debounce / hold / repeat decisions; a release always wins over a pending pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pressed) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = L_ONE;
        end
      end
      S_PRESS_WAIT: begin
        if (!w_pressed) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = L_ZERO;
        end else if (r_cnt == L_DEB) begin
          w_state_nxt = S_HELD;
          w_cnt_nxt   = L_ONE;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_HELD: begin
        if (!w_pressed) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = L_ONE;
        end else if (L_REPEAT_ON && (r_cnt == L_HOLD)) begin
          w_state_nxt = S_REPEAT;
          w_cnt_nxt   = L_ONE;
          w_pulse_nxt = 1'b1;
        end else if (r_cnt != L_HOLD) begin
          // Without repeat the count parks at HOLD_CYCLES instead of wrapping.
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_REPEAT: begin
        if (!w_pressed) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = L_ONE;
        end else if (r_cnt == L_REP) begin
          w_cnt_nxt   = L_ONE;
          w_pulse_nxt = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RELEASE_WAIT: begin
        if (w_pressed) begin
          // Bounce on release returns to HELD silently; it never produces a step.
          w_state_nxt = S_HELD;
          w_cnt_nxt   = L_ONE;
        end else if (r_cnt == L_DEB) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = L_ZERO;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = L_ZERO;
      end
    endcase
  end

  assign o_pulse = r_pulse;

endmodule

module scroll_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_EN       = 1,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic keyLeft,
  input  logic keyRight,
  output logic pulseLeft,
  output logic pulseRight
);

  // Left and right channels are identical and independent; no arbitration between them.
  scroll_key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_left (
    .clk     (clk),
    .rst_n   (reset),
    .i_key   (keyLeft),
    .o_pulse (pulseLeft)
  );

  scroll_key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES),
    .REPEAT_EN       (REPEAT_EN),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_right (
    .clk     (clk),
    .rst_n   (reset),
    .i_key   (keyRight),
    .o_pulse (pulseRight)
  );

endmodule
